// File: rtl/chimera_pkg.sv
// Shared types and default timing for the cluster power sequencer.
//   clu_pwr_state_e : sequencer FSM states
//   clu_pwr_stat_e  : stable per-cluster power status
//   *Dflt           : default timing parameters
package chimera_pkg;

  localparam int unsigned ExtClusters    = 5;
  localparam int unsigned ClkSettleDflt  = 4;
  localparam int unsigned RstCyclesDflt  = 8;
  localparam int unsigned IsoTimeoutDflt = 1024;

  typedef enum logic [2:0] {
    IDLE,
    PU_CLK,
    PU_RST,
    PU_UNISO,
    PD_ISO,
    PD_RST,
    PD_CLK
  } clu_pwr_state_e;

  typedef enum logic [1:0] {
    OFF,
    ON,
    ERR
  } clu_pwr_stat_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/chimera_clu_pwr_rr_arb.sv
// Combinational round-robin pick.
//   req_i   : request vector
//   ptr_i   : index where the upward search starts (wraps)
//   idx_o   : first requesting index at or after ptr_i
//   valid_o : any request present
module chimera_clu_pwr_rr_arb #(
  parameter int unsigned NumClusters = 5,
  parameter int unsigned PtrW        = 3
) (
  input  logic [NumClusters-1:0] req_i,
  input  logic [PtrW-1:0]        ptr_i,
  output logic [PtrW-1:0]        idx_o,
  output logic                   valid_o
);

  logic [PtrW-1:0] pos;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < NumClusters; k++) begin
      pos = PtrW'((32'(ptr_i) + k) % NumClusters);
      if (!valid_o && req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/chimera_clu_pwr_seq.sv
// Power/isolation sequencer for the external cluster domain.
// One cluster at a time is powered up (clock, reset release, unisolate) or
// powered down (isolate, reset assert, clock stop), chosen round-robin.
//   soc_clk_i   : SoC clock
//   rst_i       : synchronous active-high reset
//   target_on_i : desired run state per cluster (level)
//   clr_err_i   : per-cluster pulse, leaves ERR
//   isolated_i  : isolation status reported by each cluster domain
//   isolate_o   : isolation request to each cluster domain
//   clk_en_o    : cluster clock-gate enable
//   clu_rst_no  : cluster reset, active-low
//   on_o        : cluster in stable ON
//   err_o       : cluster in ERR (isolation handshake timed out)
//   busy_o      : a sequence is in progress
module chimera_clu_pwr_seq
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters = ExtClusters,
  parameter int unsigned ClkSettle   = ClkSettleDflt,
  parameter int unsigned RstCycles   = RstCyclesDflt,
  parameter int unsigned IsoTimeout  = IsoTimeoutDflt
) (
  input  logic                   soc_clk_i,
  input  logic                   rst_i,
  input  logic [NumClusters-1:0] target_on_i,
  input  logic [NumClusters-1:0] clr_err_i,
  input  logic [NumClusters-1:0] isolated_i,
  output logic [NumClusters-1:0] isolate_o,
  output logic [NumClusters-1:0] clk_en_o,
  output logic [NumClusters-1:0] clu_rst_no,
  output logic [NumClusters-1:0] on_o,
  output logic [NumClusters-1:0] err_o,
  output logic                   busy_o
);

  localparam int unsigned CntMax = max3(ClkSettle, RstCycles, IsoTimeout);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned PtrW   = (NumClusters > 1) ? $clog2(NumClusters) : 1;

  localparam logic [CntW-1:0] ClkLast = CntW'(ClkSettle - 1);
  localparam logic [CntW-1:0] RstLast = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] IsoLast = CntW'(IsoTimeout - 1);
  localparam logic [PtrW-1:0] SelLast = PtrW'(NumClusters - 1);

  clu_pwr_state_e  state_q, state_d;
  clu_pwr_stat_e   stat_q [NumClusters];
  clu_pwr_stat_e   stat_d [NumClusters];
  logic [PtrW-1:0] sel_q, sel_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            gnt_q, gnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [NumClusters-1:0] isolate_q, isolate_d;
  logic [NumClusters-1:0] clk_en_q, clk_en_d;
  logic [NumClusters-1:0] rst_n_q, rst_n_d;
  logic [NumClusters-1:0] on_q, on_d;
  logic [NumClusters-1:0] err_q, err_d;

  logic [NumClusters-1:0] req;
  logic [PtrW-1:0]        arb_idx;
  logic                   arb_valid;
  logic                   go_err;
  logic                   go_idle;

  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NumClusters; i++) begin
      req[i] = ((stat_q[i] == OFF) && target_on_i[i]) ||
               ((stat_q[i] == ON)  && !target_on_i[i]);
    end
  end

  chimera_clu_pwr_rr_arb #(
    .NumClusters (NumClusters),
    .PtrW        (PtrW)
  ) i_rr_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // The grant is latched in IDLE (gnt_q) and the sequence starts one edge
  // later, so the direction is taken from the status of the latched cluster.
  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q + 1'b1;
    isolate_d = isolate_q;
    clk_en_d  = clk_en_q;
    rst_n_d   = rst_n_q;
    on_d      = on_q;
    err_d     = err_q;
    go_err    = 1'b0;
    go_idle   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt_q) begin
          gnt_d = 1'b0;
          cnt_d = '0;
          if (stat_q[sel_q] == ON) begin
            state_d          = PD_ISO;
            isolate_d[sel_q] = 1'b1;
            on_d[sel_q]      = 1'b0;
          end else begin
            state_d         = PU_CLK;
            clk_en_d[sel_q] = 1'b1;
          end
        end else if (arb_valid) begin
          gnt_d = 1'b1;
          sel_d = arb_idx;
          ptr_d = (arb_idx == SelLast) ? '0 : arb_idx + 1'b1;
        end
      end
      PU_CLK: begin
        if (cnt_q == ClkLast) begin
          state_d        = PU_RST;
          cnt_d          = '0;
          rst_n_d[sel_q] = 1'b1;
        end
      end
      PU_RST: begin
        if (cnt_q == RstLast) begin
          state_d          = PU_UNISO;
          cnt_d            = '0;
          isolate_d[sel_q] = 1'b0;
        end
      end
      PU_UNISO: begin
        if (!isolated_i[sel_q]) begin
          go_idle       = 1'b1;
          stat_d[sel_q] = ON;
          on_d[sel_q]   = 1'b1;
        end else if (cnt_q == IsoLast) begin
          go_err = 1'b1;
        end
      end
      PD_ISO: begin
        if (isolated_i[sel_q]) begin
          state_d        = PD_RST;
          cnt_d          = '0;
          rst_n_d[sel_q] = 1'b0;
        end else if (cnt_q == IsoLast) begin
          go_err = 1'b1;
        end
      end
      PD_RST: begin
        if (cnt_q == RstLast) begin
          state_d = PD_CLK;
          cnt_d   = '0;
        end
      end
      PD_CLK: begin
        if (cnt_q == ClkLast) begin
          go_idle         = 1'b1;
          clk_en_d[sel_q] = 1'b0;
          stat_d[sel_q]   = OFF;
        end
      end
      default: go_idle = 1'b1;
    endcase

    if (go_err) begin
      go_idle          = 1'b1;
      stat_d[sel_q]    = ERR;
      err_d[sel_q]     = 1'b1;
      isolate_d[sel_q] = 1'b1;
      clk_en_d[sel_q]  = 1'b1;
      rst_n_d[sel_q]   = 1'b0;
      on_d[sel_q]      = 1'b0;
    end

    if (go_idle) begin
      state_d = IDLE;
      cnt_d   = '0;
    end

    for (int unsigned i = 0; i < NumClusters; i++) begin
      if (clr_err_i[i] && (stat_q[i] == ERR)) begin
        stat_d[i] = OFF;
        err_d[i]  = 1'b0;
        if (!(((state_q != IDLE) || gnt_q) && (sel_q == PtrW'(i)))) begin
          clk_en_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge soc_clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      stat_q    <= '{default: OFF};
      sel_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
      isolate_q <= '1;
      clk_en_q  <= '0;
      rst_n_q   <= '0;
      on_q      <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      isolate_q <= isolate_d;
      clk_en_q  <= clk_en_d;
      rst_n_q   <= rst_n_d;
      on_q      <= on_d;
      err_q     <= err_d;
    end
  end

  assign isolate_o  = isolate_q;
  assign clk_en_o   = clk_en_q;
  assign clu_rst_no = rst_n_q;
  assign on_o       = on_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// Bench for chimera_clu_pwr_seq with two clusters. The cluster domain is
// emulated by delaying isolate_o two cycles into isolated_i, with optional
// stuck-at overrides to provoke handshake timeouts.
module tb_chimera_clu_pwr_seq;

  localparam int unsigned N  = 2;
  localparam int unsigned CS = 4;
  localparam int unsigned RC = 8;
  localparam int unsigned IT = 16;

  logic         soc_clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] target_on_i;
  logic [N-1:0] clr_err_i;
  logic [N-1:0] isolated_i;
  logic [N-1:0] isolate_o;
  logic [N-1:0] clk_en_o;
  logic [N-1:0] clu_rst_no;
  logic [N-1:0] on_o;
  logic [N-1:0] err_o;
  logic         busy_o;

  always #5 soc_clk_i = ~soc_clk_i;

  chimera_clu_pwr_seq #(
    .NumClusters (N),
    .ClkSettle   (CS),
    .RstCycles   (RC),
    .IsoTimeout  (IT)
  ) dut (
    .soc_clk_i   (soc_clk_i),
    .rst_i       (rst_i),
    .target_on_i (target_on_i),
    .clr_err_i   (clr_err_i),
    .isolated_i  (isolated_i),
    .isolate_o   (isolate_o),
    .clk_en_o    (clk_en_o),
    .clu_rst_no  (clu_rst_no),
    .on_o        (on_o),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  logic [N-1:0] iso_d1 = '1;
  logic [N-1:0] iso_d2 = '1;
  logic [N-1:0] frc_lo = '0;
  logic [N-1:0] frc_hi = '0;

  always @(posedge soc_clk_i) begin
    iso_d1 <= isolate_o;
    iso_d2 <= iso_d1;
  end
  assign isolated_i = (iso_d2 & ~frc_lo) | frc_hi;

  // Reference model: timestamps relative to the grant edge (edge 0).
  // Status encoding: 0 = OFF, 1 = ON, 2 = ERR.
  int           m_stat [N];
  logic [N-1:0] m_iso, m_clk, m_rstn, m_on, m_err;
  logic         m_busy;
  bit           m_act, m_up;
  int           m_sel, m_ptr, m_e, m_dn;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_stat[i] = 0;
    m_iso = '1; m_clk = '0; m_rstn = '0; m_on = '0; m_err = '0;
    m_busy = 1'b0; m_act = 1'b0; m_up = 1'b0;
    m_sel = 0; m_ptr = 0; m_e = 0; m_dn = -1;
  endtask

  task automatic m_end();
    m_act  = 1'b0;
    m_busy = 1'b0;
  endtask

  task automatic m_fail();
    m_err[m_sel]  = 1'b1;
    m_iso[m_sel]  = 1'b1;
    m_clk[m_sel]  = 1'b1;
    m_rstn[m_sel] = 1'b0;
    m_on[m_sel]   = 1'b0;
    m_stat[m_sel] = 2;
    m_end();
  endtask

  // Predicts the state after the coming rising edge from the inputs now applied.
  task automatic model_step();
    logic [N-1:0] iv;
    int           pre [N];
    int           u;
    iv = (iso_d2 & ~frc_lo) | frc_hi;
    if (rst_i) begin
      m_reset();
      return;
    end
    pre = m_stat;
    u   = 1 + CS + RC;
    if (!m_act) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!m_act && ((pre[j] == 0 && target_on_i[j]) || (pre[j] == 1 && !target_on_i[j]))) begin
          m_act = 1'b1;
          m_sel = j;
          m_up  = (pre[j] == 0);
          m_e   = 0;
          m_dn  = -1;
          m_ptr = (j + 1) % N;
        end
      end
    end else begin
      m_e++;
      if (m_up) begin
        if (m_e == 1) begin
          m_clk[m_sel] = 1'b1;
          m_busy       = 1'b1;
        end
        if (m_e == 1 + CS) m_rstn[m_sel] = 1'b1;
        if (m_e == u) m_iso[m_sel] = 1'b0;
        if (m_e > u) begin
          if (!iv[m_sel]) begin
            m_stat[m_sel] = 1;
            m_on[m_sel]   = 1'b1;
            m_end();
          end else if (m_e == u + IT) begin
            m_fail();
          end
        end
      end else begin
        if (m_e == 1) begin
          m_iso[m_sel] = 1'b1;
          m_on[m_sel]  = 1'b0;
          m_busy       = 1'b1;
        end else if (m_dn < 0) begin
          if (iv[m_sel]) begin
            m_dn          = m_e;
            m_rstn[m_sel] = 1'b0;
          end else if (m_e == 1 + IT) begin
            m_fail();
          end
        end else if (m_e == m_dn + RC + CS) begin
          m_clk[m_sel]  = 1'b0;
          m_stat[m_sel] = 0;
          m_end();
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (clr_err_i[i] && pre[i] == 2) begin
        m_stat[i] = 0;
        m_err[i]  = 1'b0;
        if (!(m_act && m_sel == i)) m_clk[i] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    check("isolate_o", isolate_o, m_iso);
    check("clk_en_o", clk_en_o, m_clk);
    check("clu_rst_no", clu_rst_no, m_rstn);
    check("on_o", on_o, m_on);
    check("err_o", err_o, m_err);
    check("busy_o", busy_o, m_busy);
  endtask

  task automatic tick();
    model_step();
    @(posedge soc_clk_i);
    @(negedge soc_clk_i);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int frc_left;

  initial begin
    m_reset();
    rst_i       = 1'b1;
    target_on_i = 2'b11;
    clr_err_i   = '0;

    // Reset with both targets requested
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_isolate", isolate_o, 2'b11);
      check("rst_clk_en", clk_en_o, 2'b00);
      check("rst_rstn", clu_rst_no, 2'b00);
      check("rst_busy", busy_o, 1'b0);
    end
    target_on_i = 2'b00;
    rst_i       = 1'b0;
    run(3);

    // Single power-up of cluster 0, edge-exact
    target_on_i = 2'b01;
    for (int n = 1; n <= 18; n++) begin
      tick();
      check("pu_clk_en0", clk_en_o[0], n >= 2);
      check("pu_rstn0", clu_rst_no[0], n >= 6);
      check("pu_iso0", isolate_o[0], n < 14);
      check("pu_on0", on_o[0], n >= 17);
      check("pu_c1_quiet", {isolate_o[1], clk_en_o[1], clu_rst_no[1], on_o[1]}, 4'b1000);
    end

    // Power cluster 0 down, then request both at once, then drop both
    target_on_i = 2'b00;
    run(40);
    target_on_i = 2'b11;
    run(60);
    check("arb_both_on", on_o, 2'b11);
    target_on_i = 2'b00;
    run(60);
    check("arb_both_off", on_o, 2'b00);

    // Power-down isolation timeout on cluster 0
    target_on_i = 2'b01;
    run(30);
    frc_lo[0]   = 1'b1;
    target_on_i = 2'b00;
    run(20);
    check("to_err0", err_o[0], 1'b1);
    check("to_rstn0", clu_rst_no[0], 1'b0);
    check("to_iso0", isolate_o[0], 1'b1);
    clr_err_i = 2'b01;
    tick();
    clr_err_i = 2'b00;
    frc_lo    = '0;
    check("clr_err0", err_o[0], 1'b0);
    check("clr_clk_en0", clk_en_o[0], 1'b0);
    run(10);
    check("no_repower_busy", busy_o, 1'b0);
    check("no_repower_clk", clk_en_o[0], 1'b0);

    // Target dropped during PU_RST: power-up completes, power-down follows
    target_on_i = 2'b01;
    run(8);
    target_on_i = 2'b00;
    run(60);

    // Reset during PU_UNISO
    target_on_i = 2'b01;
    run(16);
    rst_i = 1'b1;
    tick();
    check("mrst_isolate", isolate_o, 2'b11);
    check("mrst_clk_en", clk_en_o, 2'b00);
    check("mrst_rstn", clu_rst_no, 2'b00);
    check("mrst_on", on_o, 2'b00);
    check("mrst_busy", busy_o, 1'b0);
    rst_i       = 1'b0;
    target_on_i = 2'b00;
    run(5);

    // Randomized traffic
    frc_left = 0;
    for (int c = 0; c < 5000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 39) == 0) target_on_i[i] = ~target_on_i[i];
        clr_err_i[i] = (m_stat[i] == 2 && $urandom_range(0, 7) == 0) ||
                       ($urandom_range(0, 99) == 0);
      end
      if (frc_left == 0) begin
        frc_lo = '0;
        frc_hi = '0;
        if ($urandom_range(0, 199) == 0) begin
          int ci;
          ci       = int'($urandom_range(0, N - 1));
          frc_left = int'($urandom_range(20, 80));
          if ($urandom_range(0, 1) == 0) frc_lo[ci] = 1'b1;
          else                           frc_hi[ci] = 1'b1;
        end
      end else begin
        frc_left--;
      end
      rst_i = ($urandom_range(0, 1499) == 0);
      tick();
    end
    rst_i     = 1'b0;
    clr_err_i = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
